// File: rtl/apb_rr_arbiter_if.sv
// APB bundle shared by the two upstream requesters (s_*) and the single downstream port (m_*).
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             s_psel;
  logic [1:0]             s_penable;
  logic [1:0]             s_pwrite;
  logic [1:0][ADDR_W-1:0] s_paddr;
  logic [1:0][DATA_W-1:0] s_pwdata;
  logic [1:0]             s_pready;
  logic [DATA_W-1:0]      s_prdata;
  logic                   s_pslverr;

  logic                   m_psel;
  logic                   m_penable;
  logic                   m_pwrite;
  logic [ADDR_W-1:0]      m_paddr;
  logic [DATA_W-1:0]      m_pwdata;
  logic [DATA_W-1:0]      m_prdata;
  logic                   m_pready;
  logic                   m_pslverr;

  modport master (
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    output s_pready, s_prdata, s_pslverr,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    input  m_prdata, m_pready, m_pslverr
  );

  modport slave (
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    input  s_pready, s_prdata, s_pslverr,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin APB arbiter driving one downstream APB port.
// Optional ACCESS timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  apb_rr_arbiter_if.master    bus,
  output logic                grant,
  output logic                busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_grant;
  logic              r_last;
  logic              r_abandon;
  logic              r_mwrite;
  logic [ADDR_W-1:0] r_maddr;
  logic [DATA_W-1:0] r_mwdata;

  logic              w_win;
  logic              w_start;
  logic              w_done;
  logic              w_abort;
  logic              w_owner_ok;
  logic              w_tmo;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] r_tcnt;

  assign w_tmo = (r_tcnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_tcnt <= '0;
    end else if (r_state == ST_ACCESS && !bus.m_pready) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  logic w_unused;
  assign w_unused = ^bus.s_penable;
`else
  assign w_tmo = 1'b0;

  logic w_unused;
  assign w_unused = ^{bus.s_penable, (TIMEOUT_CYC == 0)};
`endif

  // Contention goes to whoever was not served last; a lone request simply wins.
  assign w_win      = (bus.s_psel == 2'b11) ? ~r_last : bus.s_psel[1];
  // A requester that let go of psel mid-transfer no longer wants the response.
  assign w_owner_ok = bus.s_psel[r_grant] & ~r_abandon;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_start       = 1'b0;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    bus.s_pready  = 2'b00;
    bus.s_prdata  = '0;
    bus.s_pslverr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.s_psel) begin
          w_start    = 1'b1;
          w_state_nx = ST_SETUP;
        end
      end
      ST_SETUP: w_state_nx = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.m_pready) begin
          w_done     = 1'b1;
          w_state_nx = ST_IDLE;
        end else if (w_tmo) begin
          w_abort    = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if ((w_done || w_abort) && w_owner_ok) begin
      bus.s_pready[r_grant] = 1'b1;
      if (w_done) begin
        bus.s_prdata  = bus.m_prdata;
        bus.s_pslverr = bus.m_pslverr;
      end else begin
        bus.s_pslverr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_abandon <= 1'b0;
      r_mwrite  <= 1'b0;
      r_maddr   <= '0;
      r_mwdata  <= '0;
    end else begin
      if (w_start) begin
        r_grant   <= w_win;
        r_maddr   <= bus.s_paddr[w_win];
        r_mwrite  <= bus.s_pwrite[w_win];
        r_mwdata  <= bus.s_pwdata[w_win];
        r_abandon <= 1'b0;
      end else if (r_state != ST_IDLE && !bus.s_psel[r_grant]) begin
        r_abandon <= 1'b1;
      end
      if (w_done || w_abort) begin
        r_last <= r_grant;
      end
    end
  end

  assign bus.m_psel    = (r_state != ST_IDLE);
  assign bus.m_penable = (r_state == ST_ACCESS);
  assign bus.m_paddr   = r_maddr;
  assign bus.m_pwrite  = r_mwrite;
  assign bus.m_pwdata  = r_mwdata;
  assign grant         = r_grant;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: vector table, directed corner sequences and a randomized
// run against a transfer-level reference model.
module tb_apb_rr_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic grant;
  logic busy;

  always #5 clk = ~clk;

  apb_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  psel;
    logic        mrdy;
    logic [31:0] mrd;
    logic        merr;
    logic [1:0]  e_rdy;
    logic [31:0] e_rd;
    logic        e_err;
    logic        e_sel;
    logic        e_en;
    logic        e_gnt;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tv[11];

  // reference-model state for the randomized run
  logic        rq[2];
  logic [1:0]  served;
  logic        md_busy;
  int          md_phase;
  logic        md_own;
  logic        md_last;
  int          md_waits;
  logic        cmpl;
  logic        abrt;
  logic [1:0]  e_rdy;
  logic [31:0] e_rd;
  logic        e_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] rdy, input logic [31:0] rd,
                         input logic err, input logic sel, input logic en);
    chk({tag, ".s_pready"},  64'(bus.s_pready),  64'(rdy));
    chk({tag, ".s_prdata"},  64'(bus.s_prdata),  64'(rd));
    chk({tag, ".s_pslverr"}, 64'(bus.s_pslverr), 64'(err));
    chk({tag, ".m_psel"},    64'(bus.m_psel),    64'(sel));
    chk({tag, ".m_penable"}, 64'(bus.m_penable), 64'(en));
    chk({tag, ".busy"},      64'(busy),          64'(sel));
  endtask

  initial begin
    rst           = 1'b1;
    bus.s_psel    = 2'b00;
    bus.s_penable = 2'b00;
    bus.s_pwrite  = 2'b10;
    bus.s_paddr[0] = 32'h10;
    bus.s_paddr[1] = 32'h20;
    bus.s_pwdata[0] = 32'h0;
    bus.s_pwdata[1] = 32'hDEAD_BEEF;
    bus.m_prdata  = 32'h0;
    bus.m_pready  = 1'b0;
    bus.m_pslverr = 1'b0;

    // rst, psel, mrdy, mrd, merr | e_rdy, e_rd, e_err, e_sel, e_en, e_gnt, e_addr
    tv[0]  = '{1'b0, 2'b01, 1'b1, 32'hA5A5_0001, 1'b0, 2'b00, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 2'b01, 1'b1, 32'hA5A5_0001, 1'b0, 2'b00, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 32'h10};
    tv[2]  = '{1'b0, 2'b01, 1'b1, 32'hA5A5_0001, 1'b0, 2'b01, 32'hA5A5_0001,  1'b0, 1'b1, 1'b1, 1'b0, 32'h10};
    tv[3]  = '{1'b1, 2'b11, 1'b1, 32'h1111,      1'b0, 2'b00, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 2'b11, 1'b1, 32'h1111,      1'b1, 2'b00, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 2'b11, 1'b1, 32'h1111,      1'b1, 2'b00, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 32'h10};
    tv[6]  = '{1'b0, 2'b11, 1'b1, 32'h2222,      1'b0, 2'b01, 32'h2222,       1'b0, 1'b1, 1'b1, 1'b0, 32'h10};
    tv[7]  = '{1'b0, 2'b10, 1'b1, 32'h2222,      1'b0, 2'b00, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 32'h10};
    tv[8]  = '{1'b0, 2'b10, 1'b1, 32'h3333,      1'b1, 2'b00, 32'h0,          1'b0, 1'b1, 1'b0, 1'b1, 32'h20};
    tv[9]  = '{1'b0, 2'b10, 1'b1, 32'h3333,      1'b1, 2'b10, 32'h3333,       1'b1, 1'b1, 1'b1, 1'b1, 32'h20};
    tv[10] = '{1'b0, 2'b00, 1'b1, 32'h3333,      1'b1, 2'b00, 32'h0,          1'b0, 1'b0, 1'b0, 1'b1, 32'h20};

    // reset state
    repeat (2) @(posedge clk);
    smp();
    chk_out("reset", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.grant", 64'(grant), 64'd0);
    cyc();
    rst = 1'b0;

    // vector table: single read, then simultaneous requests after a reset
    for (int i = 0; i < 11; i++) begin
      cyc();
      rst           = tv[i].rst;
      bus.s_psel    = tv[i].psel;
      bus.s_penable = tv[i].psel;
      bus.m_pready  = tv[i].mrdy;
      bus.m_prdata  = tv[i].mrd;
      bus.m_pslverr = tv[i].merr;
      smp();
      chk_out($sformatf("vec%0d", i), tv[i].e_rdy, tv[i].e_rd, tv[i].e_err, tv[i].e_sel, tv[i].e_en);
      chk($sformatf("vec%0d.grant", i), 64'(grant), 64'(tv[i].e_gnt));
      chk($sformatf("vec%0d.m_paddr", i), 64'(bus.m_paddr), 64'(tv[i].e_addr));
    end

    // wait states with error response; m_* must stay stable
    cyc();
    bus.s_paddr[0] = 32'h30; bus.s_pwrite[0] = 1'b1; bus.s_pwdata[0] = 32'h1234_5678;
    bus.s_psel = 2'b01; bus.s_penable = 2'b01; bus.m_pready = 1'b0; bus.m_pslverr = 1'b0;
    cyc();
    smp();
    chk("ws.setup.grant", 64'(grant), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      chk_out($sformatf("ws%0d", k), 2'b00, 32'h0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("ws%0d.m_paddr", k), 64'(bus.m_paddr), 64'h30);
      chk($sformatf("ws%0d.m_pwdata", k), 64'(bus.m_pwdata), 64'h1234_5678);
      chk($sformatf("ws%0d.m_pwrite", k), 64'(bus.m_pwrite), 64'd1);
    end
    cyc();
    bus.m_pready = 1'b1; bus.m_pslverr = 1'b1; bus.m_prdata = 32'hCAFE;
    smp();
    chk_out("ws.done", 2'b01, 32'hCAFE, 1'b1, 1'b1, 1'b1);
    cyc();
    bus.s_psel = 2'b00; bus.s_penable = 2'b00; bus.m_pready = 1'b0; bus.m_pslverr = 1'b0;
    smp();
    chk_out("ws.idle", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("ws.idle.m_paddr_hold", 64'(bus.m_paddr), 64'h30);

    // asynchronous reset in the middle of ACCESS
    cyc();
    bus.s_psel = 2'b01; bus.s_penable = 2'b01;
    cyc();
    cyc();
    smp();
    chk("rstmid.pre.m_penable", 64'(bus.m_penable), 64'd1);
    #2;
    rst = 1'b1;
    bus.m_pready = 1'b1;
    #1;
    chk_out("rstmid", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0; bus.m_pready = 1'b0;
    bus.s_psel = 2'b11; bus.s_penable = 2'b11;
    // owner (req0) drops psel during SETUP: response discarded, next grant goes to req1
    cyc();
    bus.s_psel = 2'b10; bus.s_penable = 2'b10;
    smp();
    chk("rstmid.first_grant", 64'(grant), 64'd0);
    chk("drop.setup.busy", 64'(busy), 64'd1);
    cyc();
    bus.m_pready = 1'b1; bus.m_prdata = 32'h7777;
    smp();
    chk_out("drop.access", 2'b00, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc();
    bus.m_pready = 1'b0;
    smp();
    chk("drop.idle.busy", 64'(busy), 64'd0);
    cyc();
    smp();
    chk("drop.next_grant", 64'(grant), 64'd1);
    cyc();
    bus.m_pready = 1'b1; bus.m_prdata = 32'h8888;
    smp();
    chk_out("drop.req1", 2'b10, 32'h8888, 1'b0, 1'b1, 1'b1);
    cyc();
    bus.s_psel = 2'b00; bus.s_penable = 2'b00; bus.m_pready = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
    // timeout abort on the TMO-th ACCESS cycle without ready
    cyc();
    bus.s_psel = 2'b01; bus.s_penable = 2'b01; bus.m_prdata = 32'h5555;
    cyc();
    for (int k = 1; k <= TMO; k++) begin
      cyc();
      smp();
      if (k < TMO) chk($sformatf("tmo%0d.s_pready", k), 64'(bus.s_pready), 64'd0);
      else chk_out("tmo.abort", 2'b01, 32'h0, 1'b1, 1'b1, 1'b1);
    end
    cyc();
    bus.s_psel = 2'b00; bus.s_penable = 2'b00;
    smp();
    chk("tmo.after.m_psel", 64'(bus.m_psel), 64'd0);
`endif

    // randomized run against the reference model, from a fresh reset
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rq[0] = 1'b0; rq[1] = 1'b0; served = 2'b00;
    md_busy = 1'b0; md_phase = 0; md_own = 1'b0; md_last = 1'b1; md_waits = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        if (rq[i] && served[i]) begin
          rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          bus.s_paddr[i]  = $urandom();
          bus.s_pwdata[i] = $urandom();
          bus.s_pwrite[i] = 1'($urandom_range(0, 1));
        end
      end
      bus.s_psel    = {rq[1], rq[0]};
      bus.s_penable = {rq[1], rq[0]};
      bus.m_pready  = ($urandom_range(0, 2) != 0);
      bus.m_prdata  = $urandom();
      bus.m_pslverr = 1'($urandom_range(0, 1));
      smp();

      cmpl = md_busy && (md_phase >= 2) && bus.m_pready;
      abrt = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      abrt = md_busy && (md_phase >= 2) && !bus.m_pready && (md_waits == TMO - 1);
`endif
      e_rdy = (cmpl || abrt) ? (2'b01 << md_own) : 2'b00;
      e_rd  = cmpl ? bus.m_prdata : 32'h0;
      e_err = cmpl ? bus.m_pslverr : abrt;
      chk_out($sformatf("rnd%0d", c), e_rdy, e_rd, e_err, md_busy, md_busy && (md_phase >= 2));
      if (md_busy) begin
        chk($sformatf("rnd%0d.grant", c),    64'(grant),          64'(md_own));
        chk($sformatf("rnd%0d.m_paddr", c),  64'(bus.m_paddr),    64'(bus.s_paddr[md_own]));
        chk($sformatf("rnd%0d.m_pwdata", c), 64'(bus.m_pwdata),   64'(bus.s_pwdata[md_own]));
        chk($sformatf("rnd%0d.m_pwrite", c), 64'(bus.m_pwrite),   64'(bus.s_pwrite[md_own]));
      end
      served = e_rdy;

      if (!md_busy) begin
        if (rq[0] || rq[1]) begin
          md_own   = (rq[0] && rq[1]) ? !md_last : rq[1];
          md_busy  = 1'b1;
          md_phase = 1;
          md_waits = 0;
        end
      end else if (md_phase == 1) begin
        md_phase = 2;
      end else if (cmpl || abrt) begin
        md_busy = 1'b0;
        md_last = md_own;
      end else begin
        md_waits++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
